// File: rtl/alu_decode_stage.sv
// alu_decode_stage
// Registered RV32I decode stage for OP, OP-IMM, LUI and AUIPC. Produces ALU
// controls, operand selects, immediate and register indices for execute.
// One output register with a valid/ready handshake on each side; no skid
// buffer, so in_ready is combinational from the output side.
//
// Unsupported or malformed instructions are not dropped. They travel through
// the handshake with illegal=1, alu_op/a_sel/use_imm/imm/rs1/rs2 zeroed and
// reg_write=0. rd keeps the raw instr[11:7] field so a trap handler can see it.
// rs1 is only reported for OP/OP-IMM (LUI/AUIPC carry immediate bits there).
module alu_decode_stage #(
    parameter bit SUPPRESS_X0_WRITE = 1'b1,
    parameter bit CHECK_FUNCT7      = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    input  logic        flush,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [4:0]  alu_op,
    output logic [1:0]  a_sel,
    output logic        use_imm,
    output logic [31:0] imm,
    output logic [4:0]  rs1,
    output logic [4:0]  rs2,
    output logic [4:0]  rd,
    output logic        reg_write,
    output logic        illegal,
    output logic [31:0] pc_out
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [4:0] ALU_ADD   = 5'b00000;
    localparam logic [4:0] ALU_SUB   = 5'b00001;
    localparam logic [4:0] ALU_XOR   = 5'b00010;
    localparam logic [4:0] ALU_OR    = 5'b00011;
    localparam logic [4:0] ALU_AND   = 5'b00100;
    localparam logic [4:0] ALU_SLL   = 5'b00101;
    localparam logic [4:0] ALU_SRL   = 5'b00110;
    localparam logic [4:0] ALU_SRA   = 5'b00111;
    localparam logic [4:0] ALU_SLT   = 5'b01000;
    localparam logic [4:0] ALU_SLTU  = 5'b01001;
    localparam logic [4:0] ALU_ADDI  = 5'b01010;
    localparam logic [4:0] ALU_XORI  = 5'b01011;
    localparam logic [4:0] ALU_ORI   = 5'b01100;
    localparam logic [4:0] ALU_ANDI  = 5'b01101;
    localparam logic [4:0] ALU_SLLI  = 5'b01110;
    localparam logic [4:0] ALU_SRLI  = 5'b01111;
    localparam logic [4:0] ALU_SRAI  = 5'b10000;
    localparam logic [4:0] ALU_SLTI  = 5'b10001;
    localparam logic [4:0] ALU_SLTIU = 5'b10010;

    localparam logic [1:0] ASEL_RS1  = 2'd0;
    localparam logic [1:0] ASEL_PC   = 2'd1;
    localparam logic [1:0] ASEL_ZERO = 2'd2;

    // Instruction fields
    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [6:0]  w_funct7;
    logic        w_alt;
    logic [31:0] w_imm_i;
    logic [31:0] w_imm_sh;
    logic [31:0] w_imm_u;

    assign w_opcode = instr[6:0];
    assign w_funct3 = instr[14:12];
    assign w_funct7 = instr[31:25];
    assign w_alt    = instr[30];
    assign w_imm_i  = {{20{instr[31]}}, instr[31:20]};
    assign w_imm_sh = {27'b0, instr[24:20]};
    assign w_imm_u  = {instr[31:12], 12'b0};

    // funct7 qualifiers. With checking off only bit30 matters, so every
    // funct7 pattern is accepted and bit30 alone picks the alternate op.
    logic w_f7_ok_plain;
    logic w_f7_ok_alt;

    assign w_f7_ok_plain = CHECK_FUNCT7 ? (w_funct7 == 7'h00) : 1'b1;
    assign w_f7_ok_alt   = CHECK_FUNCT7 ? ((w_funct7 == 7'h00) || (w_funct7 == 7'h20)) : 1'b1;

    // Decoded bundle before the output register
    logic [4:0]  w_alu_op;
    logic [1:0]  w_a_sel;
    logic        w_use_imm;
    logic [31:0] w_imm;
    logic [4:0]  w_rs1;
    logic [4:0]  w_rs2;
    logic [4:0]  w_rd;
    logic        w_legal;
    logic        w_reg_write;

    // Opcode / funct decode; illegal encodings are scrubbed at the end
    always_comb begin
        w_alu_op  = ALU_ADD;
        w_a_sel   = ASEL_RS1;
        w_use_imm = 1'b0;
        w_imm     = 32'b0;
        w_rs1     = 5'b0;
        w_rs2     = 5'b0;
        w_legal   = 1'b0;
        w_rd      = instr[11:7];

        case (w_opcode)
            OPC_OP: begin
                w_rs1 = instr[19:15];
                w_rs2 = instr[24:20];
                case (w_funct3)
                    3'b000: begin
                        w_alu_op = w_alt ? ALU_SUB : ALU_ADD;
                        w_legal  = w_f7_ok_alt;
                    end
                    3'b001: begin
                        w_alu_op = ALU_SLL;
                        w_legal  = w_f7_ok_plain;
                    end
                    3'b010: begin
                        w_alu_op = ALU_SLT;
                        w_legal  = w_f7_ok_plain;
                    end
                    3'b011: begin
                        w_alu_op = ALU_SLTU;
                        w_legal  = w_f7_ok_plain;
                    end
                    3'b100: begin
                        w_alu_op = ALU_XOR;
                        w_legal  = w_f7_ok_plain;
                    end
                    3'b101: begin
                        w_alu_op = w_alt ? ALU_SRA : ALU_SRL;
                        w_legal  = w_f7_ok_alt;
                    end
                    3'b110: begin
                        w_alu_op = ALU_OR;
                        w_legal  = w_f7_ok_plain;
                    end
                    default: begin
                        w_alu_op = ALU_AND;
                        w_legal  = w_f7_ok_plain;
                    end
                endcase
            end

            OPC_OP_IMM: begin
                w_rs1     = instr[19:15];
                w_use_imm = 1'b1;
                w_imm     = w_imm_i;
                w_legal   = 1'b1;
                case (w_funct3)
                    3'b000: w_alu_op = ALU_ADDI;
                    3'b010: w_alu_op = ALU_SLTI;
                    3'b011: w_alu_op = ALU_SLTIU;
                    3'b100: w_alu_op = ALU_XORI;
                    3'b110: w_alu_op = ALU_ORI;
                    3'b111: w_alu_op = ALU_ANDI;
                    3'b001: begin
                        w_alu_op = ALU_SLLI;
                        w_imm    = w_imm_sh;
                        w_legal  = w_f7_ok_plain;
                    end
                    default: begin
                        w_alu_op = w_alt ? ALU_SRAI : ALU_SRLI;
                        w_imm    = w_imm_sh;
                        w_legal  = w_f7_ok_alt;
                    end
                endcase
            end

            OPC_LUI: begin
                w_alu_op  = ALU_ADDI;
                w_a_sel   = ASEL_ZERO;
                w_use_imm = 1'b1;
                w_imm     = w_imm_u;
                w_legal   = 1'b1;
            end

            OPC_AUIPC: begin
                w_alu_op  = ALU_ADDI;
                w_a_sel   = ASEL_PC;
                w_use_imm = 1'b1;
                w_imm     = w_imm_u;
                w_legal   = 1'b1;
            end

            default: begin
                w_legal = 1'b0;
            end
        endcase

        if (!w_legal) begin
            w_alu_op  = ALU_ADD;
            w_a_sel   = ASEL_RS1;
            w_use_imm = 1'b0;
            w_imm     = 32'b0;
            w_rs1     = 5'b0;
            w_rs2     = 5'b0;
        end
    end

    assign w_reg_write = w_legal && (!SUPPRESS_X0_WRITE || (w_rd != 5'd0));

    // Handshake
    logic r_out_valid;
    logic w_in_ready;
    logic w_capture;

    assign w_in_ready = !r_out_valid || out_ready;
    assign w_capture  = in_valid && w_in_ready && !flush;

    // Output valid: flush wins, then capture, then drain on accept
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_out_valid <= 1'b0;
        end else if (w_capture) begin
            r_out_valid <= 1'b1;
        end else if (out_ready) begin
            r_out_valid <= 1'b0;
        end
    end

    logic [4:0]  r_alu_op;
    logic [1:0]  r_a_sel;
    logic        r_use_imm;
    logic [31:0] r_imm;
    logic [4:0]  r_rs1;
    logic [4:0]  r_rs2;
    logic [4:0]  r_rd;
    logic        r_reg_write;
    logic        r_illegal;
    logic [31:0] r_pc;

    // Payload register: loads only on capture so a stalled bundle holds bit-exact
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_alu_op    <= 5'b0;
            r_a_sel     <= 2'b0;
            r_use_imm   <= 1'b0;
            r_imm       <= 32'b0;
            r_rs1       <= 5'b0;
            r_rs2       <= 5'b0;
            r_rd        <= 5'b0;
            r_reg_write <= 1'b0;
            r_illegal   <= 1'b0;
            r_pc        <= 32'b0;
        end else if (w_capture) begin
            r_alu_op    <= w_alu_op;
            r_a_sel     <= w_a_sel;
            r_use_imm   <= w_use_imm;
            r_imm       <= w_imm;
            r_rs1       <= w_rs1;
            r_rs2       <= w_rs2;
            r_rd        <= w_rd;
            r_reg_write <= w_reg_write;
            r_illegal   <= !w_legal;
            r_pc        <= pc;
        end
    end

    assign in_ready  = w_in_ready;
    assign out_valid = r_out_valid;
    assign alu_op    = r_alu_op;
    assign a_sel     = r_a_sel;
    assign use_imm   = r_use_imm;
    assign imm       = r_imm;
    assign rs1       = r_rs1;
    assign rs2       = r_rs2;
    assign rd        = r_rd;
    assign reg_write = r_reg_write;
    assign illegal   = r_illegal;
    assign pc_out    = r_pc;

endmodule
